booth_divider: RTL



---
 rtl/div_pkg.sv | 35 +++
 rtl/div_controller.sv | 108 ++++++++++
 rtl/booth_divider.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the signed restoring divider (booth_divider):
//   - state_t    : controller states IDLE / CALC / FIX / DONE
//   - DIV_WIDTH_IN / DIV_WIDTH_DIVIDEND : default operand widths
//   - abs_u      : two's-complement magnitude of a dividend-width value
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH_IN       = 16;
    localparam int DIV_WIDTH_DIVIDEND = 2 * DIV_WIDTH_IN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of val. When is_signed is 0 the value is already a magnitude.
    // The most negative input maps to 2^(N-1), which still fits as unsigned.
    function automatic logic [DIV_WIDTH_DIVIDEND-1:0] abs_u(
        input logic [DIV_WIDTH_DIVIDEND-1:0] val,
        input logic                          is_signed
    );
        logic [DIV_WIDTH_DIVIDEND-1:0] mag;
        if (is_signed && val[DIV_WIDTH_DIVIDEND-1]) begin
            mag = ~val + DIV_WIDTH_DIVIDEND'(1);
        end else begin
            mag = val;
        end
        return mag;
    endfunction

endpackage

// File: rtl/div_controller.sv
// -----------------------------------------------------------------------------
// div_controller
// FSM and iteration counter of booth_divider.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   valid_in    : operand valid from the source
//   early_exc   : divide-by-zero / early overflow detected on the live operands
//   ready       : registered, high only in IDLE
//   valid_out   : registered, one-cycle pulse while in DONE
//   load_en     : accept of a normal operation (datapath captures operands)
//   early_en    : accept of an early exception (datapath loads result regs)
//   iter_en     : one restoring step this cycle
//   fix_en      : sign/range fix-up this cycle (result regs load)
// -----------------------------------------------------------------------------
module div_controller
    import div_pkg::*;
#(
    parameter int WIDTH_IN = DIV_WIDTH_IN,
    parameter int CNT_W    = $clog2(WIDTH_IN + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_in,
    input  logic early_exc,
    output logic ready,
    output logic valid_out,
    output logic load_en,
    output logic early_en,
    output logic iter_en,
    output logic fix_en
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH_IN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             accept_s;

    // ready_q is high exactly when the FSM sits in IDLE
    assign accept_s  = valid_in & ready_q;
    assign load_en   = accept_s & ~early_exc;
    assign early_en  = accept_s & early_exc;
    assign iter_en   = (state_q == CALC);
    assign fix_en    = (state_q == FIX);
    assign ready     = ready_q;
    assign valid_out = valid_q;

    // Next-state logic; ready/valid_out are computed one cycle ahead so they come from flops
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    ready_d = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    if (early_exc) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            CALC: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                state_d = DONE;
                valid_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                ready_d = 1'b1;
            end
        endcase
    end

    // State, counter and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/booth_divider.sv
// -----------------------------------------------------------------------------
// booth_divider
// Sequential signed radix-2 restoring divider: 2W-bit dividend / W-bit divisor
// -> W-bit quotient (truncated toward zero) and W-bit remainder (sign of the
// dividend). Datapath lives here; the FSM is in div_controller.
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   dividend, divisor     : operands, captured when valid_in && ready
//   valid_in / ready      : operand handshake
//   valid_out             : one-cycle result pulse
//   quotient, remainder   : result registers (hold until next result)
//   div_by_zero, overflow : exception flags, qualified by valid_out
// Optional macro DIV_UNSIGNED_SEL_EN adds input unsigned_sel (1 = unsigned
// operands). Without it the block is always signed.
// -----------------------------------------------------------------------------
module booth_divider
    import div_pkg::*;
#(
    parameter int WIDTH_IN       = DIV_WIDTH_IN,
    parameter int WIDTH_DIVIDEND = DIV_WIDTH_DIVIDEND,
    parameter int CNT_W          = $clog2(WIDTH_IN + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH_DIVIDEND-1:0] dividend,
    input  logic [WIDTH_IN-1:0]       divisor,
    input  logic                      valid_in,
`ifdef DIV_UNSIGNED_SEL_EN
    input  logic                      unsigned_sel,
`endif
    output logic                      ready,
    output logic                      valid_out,
    output logic [WIDTH_IN-1:0]       quotient,
    output logic [WIDTH_IN-1:0]       remainder,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int W = WIDTH_IN;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};

    logic                      signed_mode_s;
    logic [WIDTH_DIVIDEND-1:0] dvd_abs_s, dvs_ext_s, dvs_abs_s;
    logic [W-1:0]              dvd_hi_s;
    logic                      dbz_s, early_ovf_s, early_exc_s;
    logic                      load_en, early_en, iter_en, fix_en;
    logic [W:0]                rem_shift_s;
    logic [W-1:0]              rem_sub_s;
    logic                      sub_ok_s;
    logic [W-1:0]              q_fix_s, r_fix_s;
    logic                      fix_ovf_s;

    // Partial remainder is kept W bits wide: after each step it is below the
    // divisor, so only the shifted value needs the extra bit.
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] lo_q, lo_d;        // low dividend bits, becomes quotient magnitude
    logic [W-1:0] dvs_q, dvs_d;
    logic         q_neg_q, q_neg_d;
    logic         r_neg_q, r_neg_d;
    logic         signed_q, signed_d;
    logic [W-1:0] quotient_q, quotient_d;
    logic [W-1:0] remainder_q, remainder_d;
    logic         dbz_q, dbz_d;
    logic         ovf_q, ovf_d;

`ifdef DIV_UNSIGNED_SEL_EN
    assign signed_mode_s = ~unsigned_sel;
`else
    assign signed_mode_s = 1'b1;
`endif

    // Magnitudes and early exception detection on the live operands
    assign dvd_abs_s   = abs_u(dividend, signed_mode_s);
    assign dvs_ext_s   = {{(WIDTH_DIVIDEND-W){divisor[W-1] & signed_mode_s}}, divisor};
    assign dvs_abs_s   = abs_u(dvs_ext_s, signed_mode_s);
    assign dvd_hi_s    = dvd_abs_s[WIDTH_DIVIDEND-1:W];
    assign dbz_s       = (divisor == {W{1'b0}});
    assign early_ovf_s = ({{(WIDTH_DIVIDEND-W){1'b0}}, dvd_hi_s} >= dvs_abs_s);
    assign early_exc_s = dbz_s | early_ovf_s;

    // One restoring step: modulo-2^W subtraction is exact because the result is below the divisor
    assign rem_shift_s = {rem_q, lo_q[W-1]};
    assign sub_ok_s    = (rem_shift_s >= {1'b0, dvs_q});
    assign rem_sub_s   = rem_shift_s[W-1:0] - dvs_q;

    // Sign application and signed range check. In unsigned mode the early check
    // already guarantees the quotient is below 2^W.
    assign q_fix_s   = q_neg_q ? (~lo_q + W'(1)) : lo_q;
    assign r_fix_s   = r_neg_q ? (~rem_q + W'(1)) : rem_q;
    assign fix_ovf_s = signed_q & (q_neg_q ? (lo_q > MIN_MAG) : (lo_q > MAX_POS));

    div_controller #(
        .WIDTH_IN (WIDTH_IN),
        .CNT_W    (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .early_exc (early_exc_s),
        .ready     (ready),
        .valid_out (valid_out),
        .load_en   (load_en),
        .early_en  (early_en),
        .iter_en   (iter_en),
        .fix_en    (fix_en)
    );

    // Datapath next-state: capture, early result, iterate, fix-up
    always_comb begin
        rem_d       = rem_q;
        lo_d        = lo_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        signed_d    = signed_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        if (load_en) begin
            rem_d    = dvd_hi_s;
            lo_d     = dvd_abs_s[W-1:0];
            dvs_d    = dvs_abs_s[W-1:0];
            q_neg_d  = signed_mode_s & (dividend[WIDTH_DIVIDEND-1] ^ divisor[W-1]);
            r_neg_d  = signed_mode_s & dividend[WIDTH_DIVIDEND-1];
            signed_d = signed_mode_s;
        end else if (early_en) begin
            remainder_d = {W{1'b0}};
            if (dbz_s) begin
                quotient_d = {W{1'b1}};
                dbz_d      = 1'b1;
                ovf_d      = 1'b0;
            end else begin
                quotient_d = {W{1'b0}};
                dbz_d      = 1'b0;
                ovf_d      = 1'b1;
            end
        end else if (iter_en) begin
            if (sub_ok_s) begin
                rem_d = rem_sub_s;
            end else begin
                rem_d = rem_shift_s[W-1:0];
            end
            lo_d = {lo_q[W-2:0], sub_ok_s};
        end else if (fix_en) begin
            dbz_d = 1'b0;
            if (fix_ovf_s) begin
                quotient_d  = {W{1'b0}};
                remainder_d = {W{1'b0}};
                ovf_d       = 1'b1;
            end else begin
                quotient_d  = q_fix_s;
                remainder_d = r_fix_s;
                ovf_d       = 1'b0;
            end
        end else begin
            rem_d = rem_q;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q       <= {W{1'b0}};
            lo_q        <= {W{1'b0}};
            dvs_q       <= {W{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            signed_q    <= 1'b0;
            quotient_q  <= {W{1'b0}};
            remainder_q <= {W{1'b0}};
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            signed_q    <= signed_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
